// File: rtl/qaccum_seq_pkg.sv
// Shared Q-format helpers for the accumulating stages downstream of the
// sign-magnitude multiplier.
package qaccum_seq_pkg;

  localparam int DEF_Q     = 15;
  localparam int DEF_N     = 32;
  localparam int DEF_GUARD = 8;

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} ostate_t;

  typedef struct packed {
    logic [DEF_N-1:0] data;
    logic             sat;
  } qres_t;

  function automatic int acc_width(input int n, input int guard);
    return n + guard;
  endfunction

endpackage

// File: rtl/qaccum_seq_qsat_sm.sv
// Wide two's-complement to N-bit sign-magnitude with magnitude clamp.
// Reusable by any accumulating stage that hands results to a sign-magnitude consumer.
module qsat_sm #(
  parameter int N     = 32,
  parameter int ACC_W = 40
) (
  input  logic [ACC_W-1:0] acc,
  output logic [N-1:0]     sm,
  output logic             sat
);

  localparam logic [ACC_W-1:0] MAX_MAG = {{(ACC_W-N+1){1'b0}}, {(N-1){1'b1}}};

  logic             neg;
  logic [ACC_W-1:0] mag;
  logic [ACC_W-1:0] mag_c;

  always_comb begin
    neg   = acc[ACC_W-1];
    // Unsigned negate is correct even for the most negative value.
    mag   = neg ? (~acc + 1'b1) : acc;
    sat   = (mag > MAX_MAG);
    mag_c = sat ? MAX_MAG : mag;
    sm    = {neg & (|mag_c), mag_c[N-2:0]};
  end

endmodule

// File: rtl/qaccum_seq.sv
// Grouped saturating accumulator for Q-format sign-magnitude products;
// one sign-magnitude result per in_last-delimited group.
module qaccum_seq
  import qaccum_seq_pkg::*;
#(
  parameter int Q     = DEF_Q,
  parameter int N     = DEF_N,
  parameter int GUARD = DEF_GUARD
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  input  logic         in_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
  output logic         out_sat
);

  localparam int ACC_W = acc_width(N, GUARD);
  localparam logic signed [ACC_W:0] ACC_MAX = {2'b00, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] ACC_MIN = -ACC_MAX;

  if (Q >= N - 1) begin : g_bad_q
    $error("qaccum_seq: Q must leave at least one integer bit");
  end

  ostate_t                 state;
  logic signed [ACC_W-1:0] acc;
  logic                    first;
  logic                    sat_flag;

  logic                    in_xfer, out_xfer;
  logic [ACC_W-1:0]        mag_ext;
  logic signed [ACC_W-1:0] term;
  logic signed [ACC_W:0]   sum;
  logic signed [ACC_W-1:0] acc_nxt;
  logic                    add_sat;
  logic                    grp_sat;
  logic [N-1:0]            res_sm;
  logic                    res_clamp;

  assign out_valid = (state == FULL);
  assign in_ready  = !out_valid || out_ready;
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid && out_ready;

  always_comb begin
    mag_ext = {{(GUARD+1){1'b0}}, in_data[N-2:0]};
    // Negative zero collapses to zero through the negate.
    term    = in_data[N-1] ? (ACC_W'(0) - mag_ext) : mag_ext;
    sum     = {acc[ACC_W-1], acc} + {term[ACC_W-1], term};
    add_sat = 1'b0;
    if (first) begin
      acc_nxt = term;
    end else if (sum > ACC_MAX) begin
      acc_nxt = ACC_MAX[ACC_W-1:0];
      add_sat = 1'b1;
    end else if (sum < ACC_MIN) begin
      acc_nxt = ACC_MIN[ACC_W-1:0];
      add_sat = 1'b1;
    end else begin
      acc_nxt = sum[ACC_W-1:0];
    end
    grp_sat = sat_flag | add_sat;
  end

  qsat_sm #(.N(N), .ACC_W(ACC_W)) u_sat (
    .acc (acc_nxt),
    .sm  (res_sm),
    .sat (res_clamp)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= EMPTY;
      out_data <= '0;
      out_sat  <= 1'b0;
      acc      <= '0;
      first    <= 1'b1;
      sat_flag <= 1'b0;
    end else begin
      if (in_xfer) begin
        acc <= acc_nxt;
        if (in_last) begin
          first    <= 1'b1;
          sat_flag <= 1'b0;
          out_data <= res_sm;
          out_sat  <= grp_sat | res_clamp;
          state    <= FULL;
        end else begin
          first    <= 1'b0;
          sat_flag <= grp_sat;
        end
      end
      if (out_xfer && !(in_xfer && in_last))
        state <= EMPTY;
    end
  end

endmodule

// File: tb/tb_qaccum_seq.sv
// Directed-vector bench for qaccum_seq; expected group results go through a
// scoreboard queue that a negedge monitor drains on every output transfer.
module tb_qaccum_seq;
  import qaccum_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_last;
  logic [31:0] in_data;
  logic        out_valid, out_ready, out_sat;
  logic [31:0] out_data;

  int checks = 0;
  int errors = 0;
  int stalls = 0;
  qres_t exp_q[$];

  always #5 clk = ~clk;

  qaccum_seq #(.Q(15), .N(32), .GUARD(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_sat(out_sat)
  );

  // Monitor: every output transfer must match the oldest expected result.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output got data=%h sat=%0b, none expected", out_data, out_sat);
      end else begin
        qres_t e;
        e = exp_q.pop_front();
        if (out_data !== e.data || out_sat !== e.sat) begin
          errors++;
          $display("FAIL group_result got data=%h sat=%0b want data=%h sat=%0b",
                   out_data, out_sat, e.data, e.sat);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask

  // Drive one term; when it closes a group, queue the hand-computed result.
  task automatic send(input logic [31:0] d, input logic l,
                      input logic [31:0] ed = '0, input logic es = 1'b0);
    int n = 0;
    in_valid = 1'b1; in_data = d; in_last = l;
    if (l) exp_q.push_back('{data: ed, sat: es});
    forever begin
      @(negedge clk);
      if (in_ready) break;
      stalls++;
      if (++n > 50) begin
        errors++;
        $display("FAIL send_timeout in_ready stuck low for term %h", d);
        break;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  initial begin
    logic [31:0] held;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_out_data", out_data, 32'h0);
    check("reset_out_sat", 32'(out_sat), 32'd0);
    check("reset_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;

    // 1: mixed-sign group, 1.0 + 2.0 - 0.5 = 2.5
    send(32'h0000_8000, 1'b0);
    send(32'h0001_0000, 1'b0);
    send(32'h8000_4000, 1'b1, 32'h0001_4000, 1'b0);
    @(negedge clk);
    check("latency_one_cycle", 32'(out_valid), 32'd1);
    @(posedge clk); #1;

    // 2: single-term groups, negative value and negative zero
    send(32'h8000_8000, 1'b1, 32'h8000_8000, 1'b0);
    send(32'h8000_0000, 1'b1, 32'h0000_0000, 1'b0);

    // 3: output clamp in both directions
    repeat (3) send(32'h7FFF_FFFF, 1'b0);
    send(32'h7FFF_FFFF, 1'b1, 32'h7FFF_FFFF, 1'b1);
    repeat (3) send(32'hFFFF_FFFF, 1'b0);
    send(32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1);
    @(posedge clk); #1;

    // 4: backpressure holds the result and stalls the input
    out_ready = 1'b0;
    send(32'h0001_8000, 1'b1, 32'h0001_8000, 1'b0);
    @(negedge clk);
    held = out_data;
    for (int i = 0; i < 3; i++) begin
      check("bp_in_ready_low", 32'(in_ready), 32'd0);
      check("bp_out_data_stable", out_data, held);
      if (i < 2) @(negedge clk);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    stalls = 0;
    send(32'h0000_8000, 1'b1, 32'h0000_8000, 1'b0);
    check("bp_accept_with_drain", 32'(stalls), 32'd0);
    @(negedge clk);
    check("bp_replaced_valid", 32'(out_valid), 32'd1);
    @(posedge clk); #1;

    // 5: back-to-back single-term groups at full rate
    stalls = 0;
    for (int k = 1; k <= 4; k++)
      send(32'(k) << 15, 1'b1, 32'(k) << 15, 1'b0);
    check("b2b_no_stall", 32'(stalls), 32'd0);
    @(posedge clk); #1;

    // 6: reset mid-group drops the partial sum
    send(32'h0000_8000, 1'b0);
    send(32'h0000_8000, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check("rst_during_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_after_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    send(32'h0000_4000, 1'b1, 32'h0000_4000, 1'b0);

    repeat (3) @(posedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
